// File: rtl/sync_queue_pkg.sv
// Shared constants, pointer type and flag helper for sync_queue.
// Ports: none (package).
package sync_queue_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // One extra pointer bit over the index width gives the wrap lap bit.
  function automatic int ptrBits(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W = ptrBits(DEFAULT_DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  // Full when the index bits match but the pointers are a lap apart.
  function automatic logic is_full(
    input logic [31:0] wrPtr,
    input logic [31:0] rdPtr,
    input int          addrW
  );
    logic [31:0] diff;
    logic [31:0] mask;
    diff = wrPtr ^ rdPtr;
    mask = (32'd1 << addrW) - 32'd1;
    return ((diff & mask) == 32'd0) && diff[addrW];
  endfunction

endpackage

// File: rtl/sync_queue_storage.sv
// queue_storage: WIDTH x DEPTH register array, sync write, async read.
// Ports: clk, we, waddr, wdata, raddr, rdata. No reset on the array.
module queue_storage #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_queue.sv
// sync_queue: show-ahead synchronous FIFO with push/pop handshake.
// Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, full, empty, count;
// overflow/underflow sticky flags exist when SYNC_QUEUE_ERR_FLAGS_EN is defined.
module sync_queue
  import sync_queue_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
`ifdef SYNC_QUEUE_ERR_FLAGS_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [ADDR_W:0]   count
);

  logic [ADDR_W:0]  wrPtr;
  logic [ADDR_W:0]  rdPtr;
  logic [ADDR_W:0]  countQ;
  logic [WIDTH-1:0] headWord;
  logic             pushOk;
  logic             popOk;

  assign empty  = (wrPtr == rdPtr);
  assign full   = is_full(32'(wrPtr), 32'(rdPtr), ADDR_W);
  assign pushOk = wr_en && !full;
  assign popOk  = rd_en && !empty;
  assign count  = countQ;

  queue_storage #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) uStorage (
    .clk   (clk),
    .we    (pushOk),
    .waddr (wrPtr[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (rdPtr[ADDR_W-1:0]),
    .rdata (headWord)
  );

  // Stale storage must never leak out while empty.
  assign rd_data = empty ? '0 : headWord;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      case ({pushOk, popOk})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

`ifdef SYNC_QUEUE_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_queue.sv
// Randomised + directed bench for sync_queue against a queue-based model.
// Ports: none (top-level bench).
module tb_sync_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
`ifdef SYNC_QUEUE_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] q[$];
  bit modelValid = 1'b0;
  bit expOvf = 1'b0;
  bit expUnf = 1'b0;

  always #5 clk = ~clk;

  sync_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
`ifdef SYNC_QUEUE_ERR_FLAGS_EN
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .count     (count)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a plain queue, updated from pre-edge occupancy.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      expOvf = 1'b0;
      expUnf = 1'b0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      automatic bit wasFull  = (q.size() == DEPTH);
      automatic bit wasEmpty = (q.size() == 0);
      if (wr_en && wasFull)  expOvf = 1'b1;
      if (rd_en && wasEmpty) expUnf = 1'b1;
      if (rd_en && !wasEmpty) void'(q.pop_front());
      if (wr_en && !wasFull)  q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("rd_data", 32'(rd_data), (q.size() == 0) ? 32'd0 : 32'(q[0]));
`ifdef SYNC_QUEUE_ERR_FLAGS_EN
      chk("overflow", 32'(overflow), 32'(expOvf));
      chk("underflow", 32'(underflow), 32'(expUnf));
`endif
    end
  end

  task automatic cyc(input logic w, input logic [WIDTH-1:0] d,
                     input logic r, input logic rs);
    wr_en = w;
    wr_data = d;
    rd_en = r;
    rst = rs;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_rd", 32'(rd_data), 0);

    cyc(1, 8'h11, 0, 0);
    chk("show_ahead", 32'(rd_data), 32'h11);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'h33, 0, 0);
    cyc(1, 8'h44, 0, 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 4);

    cyc(1, 8'h55, 0, 0);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_head", 32'(rd_data), 32'h11);
`ifdef SYNC_QUEUE_ERR_FLAGS_EN
    chk("ovf_flag", 32'(overflow), 1);
`endif

    cyc(0, 8'h00, 1, 0);
    chk("drain1", 32'(rd_data), 32'h22);
    cyc(0, 8'h00, 1, 0);
    chk("drain2", 32'(rd_data), 32'h33);
    cyc(0, 8'h00, 1, 0);
    chk("drain3", 32'(rd_data), 32'h44);
    cyc(0, 8'h00, 1, 0);
    chk("drain_empty", 32'(empty), 1);

    cyc(0, 8'h00, 1, 0);
    chk("unf_count", 32'(count), 0);
`ifdef SYNC_QUEUE_ERR_FLAGS_EN
    chk("unf_flag", 32'(underflow), 1);
    chk("ovf_held", 32'(overflow), 1);
`endif

    cyc(1, 8'h0A, 0, 0);
    cyc(1, 8'h0B, 0, 0);
    cyc(1, 8'h0C, 1, 0);
    chk("pp2_count", 32'(count), 2);
    chk("pp2_head", 32'(rd_data), 32'h0B);
    cyc(1, 8'h0D, 0, 0);
    cyc(1, 8'h0E, 0, 0);
    cyc(1, 8'h0F, 1, 0);
    chk("ppfull_count", 32'(count), 3);
    chk("ppfull_head", 32'(rd_data), 32'h0C);

    cyc(0, 8'h00, 0, 1);
`ifdef SYNC_QUEUE_ERR_FLAGS_EN
    chk("flags_clr", 32'({overflow, underflow}), 0);
`endif
    cyc(1, 8'hA5, 1, 0);
    chk("ppempty_count", 32'(count), 1);
    chk("ppempty_rd", 32'(rd_data), 32'hA5);

    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'd0, 0, 0);
    cyc(1, 8'd1, 0, 0);
    for (int i = 2; i < 10; i++) cyc(1, 8'(i), 1, 0);
    chk("wrap_head", 32'(rd_data), 8);
    chk("wrap_count", 32'(count), 2);
    cyc(0, 8'h00, 1, 0);
    chk("wrap_last", 32'(rd_data), 9);
    cyc(0, 8'h00, 1, 0);

    cyc(1, 8'h61, 0, 0);
    cyc(1, 8'h62, 0, 0);
    cyc(1, 8'h63, 0, 0);
    chk("mid_count", 32'(count), 3);
    cyc(1, 8'h77, 0, 1);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_rd", 32'(rd_data), 0);

    for (int i = 0; i < 3000; i++) begin
      automatic int bias = (i / 500) % 3;
      automatic logic w = ($urandom_range(0, 9) < 3 + 2 * bias);
      automatic logic r = ($urandom_range(0, 9) < 7 - 2 * bias);
      automatic logic rs = ($urandom_range(0, 199) == 0);
      cyc(w, 8'($urandom), r, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
